// File: rtl/loop_seq_pkg.sv
// Shared types and constants for the hardware loop sequencer and its save/restore stack.
package loop_seq_pkg;

    localparam int LS_DATA_W = 16;
    localparam int LS_ADDR_W = 12;
    localparam int LS_DEPTH  = 4;

    localparam int ERR_OVF   = 0;
    localparam int ERR_UNF   = 1;
    localparam int ERR_PROTO = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACTIVE  = 2'd1,
        ST_RESTORE = 2'd2
    } state_e;

    typedef struct packed {
        logic [LS_DATA_W-1:0] count;
        logic [LS_ADDR_W-1:0] start;
    } stack_entry_t;

endpackage

// File: rtl/loop_stack.sv
// LIFO holding the suspended outer loops (count, start address); the active loop lives outside it.
module loop_stack
    import loop_seq_pkg::*;
#(
    parameter int ENTRIES = LS_DEPTH - 1
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         push,
    input  logic         pop,
    input  stack_entry_t push_data,
    output stack_entry_t top,
    output logic         full,
    output logic         empty
);

    localparam int PTR_W = $clog2(ENTRIES + 1);
    localparam logic [PTR_W-1:0] CNT_MAX = PTR_W'(ENTRIES);

    stack_entry_t     mem_q [ENTRIES];
    logic [PTR_W-1:0] cnt_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt_q == CNT_MAX);
    assign empty   = (cnt_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign top     = empty ? '0 : mem_q[cnt_q - PTR_W'(1)];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push) begin
            mem_q[cnt_q] <= push_data;
            cnt_q        <= cnt_q + PTR_W'(1);
        end else if (do_pop) begin
            cnt_q <= cnt_q - PTR_W'(1);
        end
    end

endmodule

// File: rtl/loop_sequencer.sv
// Hardware loop controller: drives loop_register strobes, PC branch-back, and nested-loop save/restore.
module loop_sequencer
    import loop_seq_pkg::*;
#(
    parameter int DATA_W = LS_DATA_W,
    parameter int ADDR_W = LS_ADDR_W,
    parameter int DEPTH  = LS_DEPTH
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       loop_open,
    input  logic                       loop_end,
    input  logic [ADDR_W-1:0]          pc_in,
    input  logic [DATA_W-1:0]          lr_value,
    input  logic                       lrz_flag,
    input  logic                       err_clr,
    output logic                       lr_we,
    output logic                       lr_decrement,
    output logic                       restore_oe,
    output logic [DATA_W-1:0]          restore_data,
    output logic                       branch_take,
    output logic [ADDR_W-1:0]          branch_addr,
    output logic                       stall,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic [2:0]                 err
);

    localparam int DEPTH_W = $clog2(DEPTH + 1);
    localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(DEPTH);

    state_e              state_q, state_d;
    logic [DEPTH_W-1:0]  depth_q, depth_d;
    logic [ADDR_W-1:0]   start_q, start_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [2:0]          err_q, err_d;

    logic                push;
    logic                pop;
    logic                loop_exit;
    stack_entry_t        stk_top;
    stack_entry_t        stk_push_data;
    logic                stk_full;
    logic                stk_empty;

    // A zero count is treated like the last iteration so a bad count can never spin forever.
    assign loop_exit     = lrz_flag || (lr_value == '0);
    assign stk_push_data = '{count: lr_value, start: start_q};

    loop_stack #(
        .ENTRIES (DEPTH - 1)
    ) u_stack (
        .clk       (clk),
        .rstn      (rstn),
        .push      (push),
        .pop       (pop),
        .push_data (stk_push_data),
        .top       (stk_top),
        .full      (stk_full),
        .empty     (stk_empty)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            depth_q <= '0;
            start_q <= '0;
            rdata_q <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            depth_q <= depth_d;
            start_q <= start_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        depth_d = depth_q;
        start_d = start_q;
        rdata_d = rdata_q;
        err_d   = err_clr ? 3'b000 : err_q;
        push    = 1'b0;
        pop     = 1'b0;
        if (state_q == ST_RESTORE) begin
            state_d = ST_ACTIVE;
            if (loop_open || loop_end) err_d[ERR_PROTO] = 1'b1;
        end else if (loop_end) begin
            if (loop_open) err_d[ERR_PROTO] = 1'b1;
            if (state_q == ST_IDLE) begin
                err_d[ERR_UNF] = 1'b1;
            end else if (loop_exit) begin
                depth_d = depth_q - DEPTH_W'(1);
                if (depth_q > DEPTH_W'(1)) begin
                    state_d = ST_RESTORE;
                    pop     = 1'b1;
                    start_d = stk_top.start;
                    rdata_d = stk_top.count;
                end else begin
                    state_d = ST_IDLE;
                end
            end
        end else if (loop_open) begin
            if (depth_q == DEPTH_MAX) begin
                err_d[ERR_OVF] = 1'b1;
            end else begin
                push    = (depth_q != '0);
                start_d = pc_in;
                depth_d = depth_q + DEPTH_W'(1);
                state_d = ST_ACTIVE;
            end
        end
    end

    always_comb begin
        lr_we        = 1'b0;
        lr_decrement = 1'b0;
        restore_oe   = 1'b0;
        branch_take  = 1'b0;
        stall        = 1'b0;
        unique case (state_q)
            ST_RESTORE: begin
                restore_oe = 1'b1;
                lr_we      = 1'b1;
                stall      = 1'b1;
            end
            ST_ACTIVE: begin
                if (loop_end) begin
                    lr_decrement = !loop_exit;
                    branch_take  = !loop_exit;
                end else if (loop_open && depth_q != DEPTH_MAX) begin
                    lr_we = 1'b1;
                end
            end
            default: begin
                lr_we = loop_open && !loop_end;
            end
        endcase
    end

    assign branch_addr  = start_q;
    assign restore_data = rdata_q;
    assign depth        = depth_q;
    assign err          = err_q;

endmodule

// File: tb/tb_loop_sequencer.sv
// Scoreboard bench: a behavioural loop model (plus a loop_register stand-in) predicts every cycle's outputs.
module tb_loop_sequencer;

    localparam int DW = 16;
    localparam int AW = 12;
    localparam int DP = 4;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          loop_open = 1'b0;
    logic          loop_end = 1'b0;
    logic [AW-1:0] pc_in = '0;
    logic [DW-1:0] lr_value = '0;
    logic          lrz_flag = 1'b0;
    logic          err_clr = 1'b0;
    logic          lr_we;
    logic          lr_decrement;
    logic          restore_oe;
    logic [DW-1:0] restore_data;
    logic          branch_take;
    logic [AW-1:0] branch_addr;
    logic          stall;
    logic [2:0]    depth;
    logic [2:0]    err;

    always #5 clk = ~clk;

    loop_sequencer dut (
        .clk          (clk),
        .rstn         (rstn),
        .loop_open    (loop_open),
        .loop_end     (loop_end),
        .pc_in        (pc_in),
        .lr_value     (lr_value),
        .lrz_flag     (lrz_flag),
        .err_clr      (err_clr),
        .lr_we        (lr_we),
        .lr_decrement (lr_decrement),
        .restore_oe   (restore_oe),
        .restore_data (restore_data),
        .branch_take  (branch_take),
        .branch_addr  (branch_addr),
        .stall        (stall),
        .depth        (depth),
        .err          (err)
    );

    typedef struct packed {
        logic          we;
        logic          dec;
        logic          roe;
        logic [DW-1:0] rdata;
        logic          bt;
        logic [AW-1:0] baddr;
        logic          stall;
        logic [2:0]    depth;
        logic [2:0]    err;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: remaining-iteration count per loop, a list of suspended loops, sticky error set.
    int                m_depth;
    bit                m_restore;
    logic [AW-1:0]     m_start;
    logic [DW-1:0]     m_rdata;
    logic [DW-1:0]     m_lr;
    logic [2:0]        m_err;
    logic [DW+AW-1:0]  m_stack[$];

    task automatic model_reset();
        m_depth   = 0;
        m_restore = 0;
        m_start   = '0;
        m_rdata   = '0;
        m_lr      = '0;
        m_err     = '0;
        m_stack.delete();
    endtask

    task automatic step(input bit rst, input bit op, input bit en,
                        input logic [AW-1:0] pc, input logic [DW-1:0] cnt, input bit clr);
        exp_t          e;
        logic [2:0]    nerr;
        logic [DW-1:0] lr_next;
        @(posedge clk);
        #1;
        lr_value  = m_lr;
        lrz_flag  = (m_lr == 1);
        loop_open = op;
        loop_end  = en;
        pc_in     = pc;
        err_clr   = clr;
        rstn      = !rst;
        if (rst) begin
            model_reset();
            e = '0;
            sb_q.push_back(e);
            return;
        end
        e       = '0;
        e.rdata = m_rdata;
        e.baddr = m_start;
        e.depth = 3'(m_depth);
        e.err   = m_err;
        nerr    = clr ? 3'b000 : m_err;
        lr_next = m_lr;
        if (m_restore) begin
            e.roe = 1; e.we = 1; e.stall = 1;
            if (op || en) nerr[2] = 1;
            lr_next   = m_rdata;
            m_restore = 0;
        end else if (en) begin
            if (op) nerr[2] = 1;
            if (m_depth == 0) begin
                nerr[1] = 1;
            end else if (m_lr <= 1) begin
                m_depth--;
                if (m_depth >= 1) begin
                    {m_rdata, m_start} = m_stack.pop_back();
                    m_restore = 1;
                end
            end else begin
                e.bt = 1; e.dec = 1;
                lr_next = m_lr - 1;
            end
        end else if (op) begin
            if (m_depth == DP) begin
                nerr[0] = 1;
            end else begin
                e.we = 1;
                lr_next = cnt;
                if (m_depth >= 1) m_stack.push_back({m_lr, m_start});
                m_start = pc;
                m_depth++;
            end
        end
        m_err = nerr;
        m_lr  = lr_next;
        sb_q.push_back(e);
    endtask

    task automatic idle();  step(0, 0, 0, '0, '0, 0); endtask
    task automatic do_end(); step(0, 0, 1, '0, '0, 0); endtask
    task automatic do_open(input logic [AW-1:0] pc, input logic [DW-1:0] cnt);
        step(0, 1, 0, pc, cnt, 0);
    endtask
    task automatic do_clr(); step(0, 0, 0, '0, '0, 1); endtask

    task automatic unwind();
        for (int i = 0; i < 60 && (m_depth != 0 || m_restore); i++) begin
            if (m_restore) idle();
            else do_end();
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("lr_we",        32'(lr_we),        32'(e.we));
                chk("lr_decrement", 32'(lr_decrement), 32'(e.dec));
                chk("restore_oe",   32'(restore_oe),   32'(e.roe));
                chk("restore_data", 32'(restore_data), 32'(e.rdata));
                chk("branch_take",  32'(branch_take),  32'(e.bt));
                chk("branch_addr",  32'(branch_addr),  32'(e.baddr));
                chk("stall",        32'(stall),        32'(e.stall));
                chk("depth",        32'(depth),        32'(e.depth));
                chk("err",          32'(err),          32'(e.err));
            end
        end
    end

    initial begin : stimulus
        bit            rst, op, en, clr;
        logic [AW-1:0] pc;
        logic [DW-1:0] cnt;
        model_reset();
        step(1, 0, 0, '0, '0, 0);
        step(1, 0, 0, '0, '0, 0);

        // underflow from reset, then clear
        do_end();
        idle();
        do_clr();

        // single loop, count 3
        do_open(12'h010, 16'd3);
        do_end(); do_end(); do_end();
        idle();

        // nested 2 @0x020 / 2 @0x030
        do_open(12'h020, 16'd2);
        do_open(12'h030, 16'd2);
        do_end(); do_end();
        idle();
        do_end(); do_end();
        idle();

        // overflow, clear, unwind
        for (int i = 0; i < 5; i++) do_open(12'h100 + 12'(i), 16'd2);
        idle();
        do_clr();
        unwind();

        // open+end together while active
        do_open(12'h040, 16'd2);
        step(0, 1, 1, 12'h0AA, 16'd5, 0);
        do_end();
        do_clr();

        // end during restore
        do_open(12'h050, 16'd1);
        do_open(12'h060, 16'd1);
        do_end();
        do_end();
        do_end();
        idle();
        do_clr();

        // zero count
        do_open(12'h070, 16'd0);
        do_end();
        idle();

        // reset while restoring at depth 2, then normal use
        do_open(12'h080, 16'd2);
        do_open(12'h090, 16'd2);
        do_open(12'h0A0, 16'd1);
        do_end();
        step(1, 0, 0, '0, '0, 0);
        do_open(12'h0B0, 16'd2);
        do_end(); do_end();
        idle();

        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(499) == 0);
            op  = ($urandom_range(99) < 30);
            en  = ($urandom_range(99) < 35);
            clr = ($urandom_range(99) < 5);
            if (m_restore && $urandom_range(3) != 0) begin
                op = 0;
                en = 0;
            end
            if (rst) begin
                op = 0;
                en = 0;
            end
            cnt = 16'($urandom_range(4));
            pc  = 12'($urandom);
            step(rst, op, en, pc, cnt, clr);
        end

        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
        @(posedge clk);
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
